// File: rtl/abus_fifo_slave.sv
// abus_fifo_slave: abus slave exposing a 4-word register window
// (DATA / STATUS / CTRL / THR) in front of a posted-write FIFO that drains
// to a valid/ready stream consumer.
// Optional feature macro: ABUS_FIFO_SLAVE_IRQ_EN enables the threshold/overflow
// level interrupt and the THR register; without it irq is tied low and THR
// reads as zero.
module abus_fifo_slave #(
  parameter int  START_ADDR = 0,
  parameter int  ADDR_WIDTH = 16,
  parameter int  DATA_WIDTH = 16,
  parameter int  DEPTH      = 8,
  parameter int  WAIT_STATE = 0,
  localparam int SK_SIZE    = $clog2(DATA_WIDTH + 1)
) (
  input  logic                  abus_clk,
  input  logic                  abus_rst,
  input  logic                  abus_sreq,
  input  logic                  abus_swrite,
  input  logic                  abus_sread,
  input  logic                  abus_sabort,
  input  logic [ADDR_WIDTH-1:0] abus_saddress,
  input  logic [DATA_WIDTH-1:0] abus_swdata,
  input  logic [SK_SIZE-1:0]    abus_sstrb,
  input  logic [SK_SIZE-1:0]    abus_skeep,
  output logic                  abus_sack,
  output logic [DATA_WIDTH-1:0] abus_srdata,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  input  logic                  m_ready,
  output logic                  irq
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [ADDR_WIDTH:0] WIN_LO     = (ADDR_WIDTH + 1)'(START_ADDR);
  localparam logic [ADDR_WIDTH:0] WIN_HI     = (ADDR_WIDTH + 1)'(START_ADDR + 4);
  localparam logic [CW-1:0]       FULL_COUNT = CW'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;

  state_t                state, state_nxt;
  logic [2:0]            wait_cnt;
  logic [ADDR_WIDTH:0]   addr_ext, addr_rel;
  logic                  hit;
  logic [1:0]            req_off;
  logic                  req_wr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  acc_fire, wr_fire;
  logic                  push_req, push_ok, pop, flush, clr_ovf;
  logic                  full, empty;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]         rd_ptr, wr_ptr, rd_ptr_nxt;
  logic [CW-1:0]         count, count_nxt;
  logic                  ovf;
  logic [DATA_WIDTH-1:0] head_nxt, status, rd_mux;
  logic                  unused_inputs;

`ifdef ABUS_FIFO_SLAVE_IRQ_EN
  logic [CW-1:0] thr;
  logic          thr_wr;
`endif

  // Window decode; the extra address bit keeps START_ADDR+4 from wrapping
  assign addr_ext      = {1'b0, abus_saddress};
  assign addr_rel      = addr_ext - WIN_LO;
  assign hit           = abus_sreq & (abus_sread ^ abus_swrite) &
                         (addr_ext >= WIN_LO) & (addr_ext < WIN_HI);
  assign unused_inputs = ^{abus_sstrb, abus_skeep, addr_rel[ADDR_WIDTH:2]};

  // Access completes only in ACK and only if not aborted that same cycle
  assign acc_fire = (state == S_ACK) & ~abus_sabort;
  assign wr_fire  = acc_fire & req_wr;
  assign push_req = wr_fire & (req_off == 2'd0);
  assign flush    = wr_fire & (req_off == 2'd2) & req_wdata[0];
  assign clr_ovf  = wr_fire & (req_off == 2'd2) & req_wdata[1];
  assign full     = (count == FULL_COUNT);
  assign empty    = (count == '0);
  assign pop      = ~empty & m_ready;
  assign push_ok  = push_req & ~full;
  assign m_valid  = ~empty;

  // FSM state register
  always_ff @(posedge abus_clk or posedge abus_rst) begin
    if (abus_rst) state <= S_IDLE;
    else          state <= state_nxt;
  end

  // FSM next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (hit && !abus_sabort) state_nxt = (WAIT_STATE > 0) ? S_WAIT : S_ACK;
      S_WAIT: begin
        if (abus_sabort)                           state_nxt = S_IDLE;
        else if (int'(wait_cnt) >= WAIT_STATE - 1) state_nxt = S_ACK;
      end
      S_ACK:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // FSM outputs: ack pulse and read data gated to the ack cycle
  always_comb begin
    abus_sack   = 1'b0;
    abus_srdata = '0;
    if (acc_fire) begin
      abus_sack = 1'b1;
      if (!req_wr) abus_srdata = rd_mux;
    end
  end

  // Wait-state counter, running only while in WAIT
  always_ff @(posedge abus_clk or posedge abus_rst) begin
    if (abus_rst)              wait_cnt <= '0;
    else if (state == S_WAIT)  wait_cnt <= wait_cnt + 3'd1;
    else                       wait_cnt <= '0;
  end

  // Capture the accepted request so the master's bus may change afterwards
  always_ff @(posedge abus_clk or posedge abus_rst) begin
    if (abus_rst) begin
      req_off   <= '0;
      req_wr    <= 1'b0;
      req_wdata <= '0;
    end else if (state == S_IDLE && hit && !abus_sabort) begin
      req_off   <= addr_rel[1:0];
      req_wr    <= abus_swrite;
      req_wdata <= abus_swdata;
    end
  end

  // STATUS layout: ovf, full, empty in the top three bits, count zero-extended below
  always_comb begin
    status                 = '0;
    status[DATA_WIDTH-1]   = ovf;
    status[DATA_WIDTH-2]   = full;
    status[DATA_WIDTH-3]   = empty;
    status[CW-1:0]         = count;
  end

  // Register read mux; DATA and CTRL read as zero
  always_comb begin
    rd_mux = '0;
    case (req_off)
      2'd1: rd_mux = status;
`ifdef ABUS_FIFO_SLAVE_IRQ_EN
      2'd3: rd_mux = DATA_WIDTH'(thr);
`endif
      default: rd_mux = '0;
    endcase
  end

  // Next head word: a push landing where the head will be bypasses the array
  always_comb begin
    rd_ptr_nxt = rd_ptr + PW'(pop);
    count_nxt  = count;
    if (push_ok) count_nxt = count_nxt + CW'(1);
    if (pop)     count_nxt = count_nxt - CW'(1);
    head_nxt = '0;
    if (!flush && count_nxt != '0)
      head_nxt = (push_ok && wr_ptr == rd_ptr_nxt) ? req_wdata : mem[rd_ptr_nxt];
  end

  // FIFO storage array
  always_ff @(posedge abus_clk) begin
    if (push_ok) mem[wr_ptr] <= req_wdata;
  end

  // FIFO pointers, occupancy, registered head word and sticky overflow
  always_ff @(posedge abus_clk or posedge abus_rst) begin
    if (abus_rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
      m_data <= '0;
    end else begin
      if (flush) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (push_ok) wr_ptr <= wr_ptr + PW'(1);
        rd_ptr <= rd_ptr_nxt;
        count  <= count_nxt;
      end
      m_data <= head_nxt;
      if (clr_ovf)              ovf <= 1'b0;
      else if (push_req && full) ovf <= 1'b1;
    end
  end

`ifdef ABUS_FIFO_SLAVE_IRQ_EN
  assign thr_wr = wr_fire & (req_off == 2'd3);

  // Threshold register and registered level interrupt
  always_ff @(posedge abus_clk or posedge abus_rst) begin
    if (abus_rst) begin
      thr <= '0;
      irq <= 1'b0;
    end else begin
      if (thr_wr) thr <= req_wdata[CW-1:0];
      irq <= ((thr != '0) && (count >= thr)) || ovf;
    end
  end
`else
  assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_abus_fifo_slave.sv
// Self-checking bench for abus_fifo_slave: two instances (no wait states at
// base 0, three wait states at base 0x40) checked against a queue-based model.
module tb_abus_fifo_slave;

  localparam int AW    = 16;
  localparam int DW    = 16;
  localparam int DEPTH = 8;
  localparam int SK    = 5;
`ifdef ABUS_FIFO_SLAVE_IRQ_EN
  localparam bit IRQ_EN = 1'b1;
`else
  localparam bit IRQ_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          sreq   [2];
  logic          swrite [2];
  logic          sread  [2];
  logic          sabort [2];
  logic          mready [2];
  logic [AW-1:0] saddr  [2];
  logic [DW-1:0] swdata [2];
  logic [SK-1:0] sstrb  = '1;
  logic [SK-1:0] skeep  = '1;
  logic          sack   [2];
  logic [DW-1:0] srdata [2];
  logic          mvalid [2];
  logic [DW-1:0] mdata  [2];
  logic          irq    [2];

  always #5 clk = ~clk;

  abus_fifo_slave #(.START_ADDR(0), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
                    .DEPTH(DEPTH), .WAIT_STATE(0)) dut0 (
    .abus_clk(clk), .abus_rst(rst), .abus_sreq(sreq[0]), .abus_swrite(swrite[0]),
    .abus_sread(sread[0]), .abus_sabort(sabort[0]), .abus_saddress(saddr[0]),
    .abus_swdata(swdata[0]), .abus_sstrb(sstrb), .abus_skeep(skeep),
    .abus_sack(sack[0]), .abus_srdata(srdata[0]), .m_valid(mvalid[0]),
    .m_data(mdata[0]), .m_ready(mready[0]), .irq(irq[0]));

  abus_fifo_slave #(.START_ADDR(16'h40), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
                    .DEPTH(DEPTH), .WAIT_STATE(3)) dut1 (
    .abus_clk(clk), .abus_rst(rst), .abus_sreq(sreq[1]), .abus_swrite(swrite[1]),
    .abus_sread(sread[1]), .abus_sabort(sabort[1]), .abus_saddress(saddr[1]),
    .abus_swdata(swdata[1]), .abus_sstrb(sstrb), .abus_skeep(skeep),
    .abus_sack(sack[1]), .abus_srdata(srdata[1]), .m_valid(mvalid[1]),
    .m_data(mdata[1]), .m_ready(mready[1]), .irq(irq[1]));

  // Reference model: one word queue per instance plus flags
  logic [15:0] q0[$];
  logic [15:0] q1[$];
  bit          ovf_m [2];
  logic [3:0]  thr_m [2];
  bit          irq_m [2];
  int          checks = 0;
  int          errors = 0;

  typedef struct {
    int          u;
    int          kind;   // 0 = bus access, 1 = idle cycles
    bit          wr;
    bit          rd;
    logic [15:0] addr;
    logic [15:0] wd;
    bit          mr;
    int          ncyc;
    bit          do_chk;
    logic [15:0] exp;
  } vec_t;

  vec_t tbl[$];

  function automatic int base_of(input int u);
    return (u == 0) ? 0 : 'h40;
  endfunction

  function automatic int ws_of(input int u);
    return (u == 0) ? 0 : 3;
  endfunction

  function automatic int qsize(input int u);
    return (u == 0) ? q0.size() : q1.size();
  endfunction

  function automatic logic [15:0] qhead(input int u);
    return (u == 0) ? q0[0] : q1[0];
  endfunction

  task automatic qpush(input int u, input logic [15:0] v);
    if (u == 0) q0.push_back(v); else q1.push_back(v);
  endtask

  task automatic qpop(input int u);
    if (u == 0) void'(q0.pop_front()); else void'(q1.pop_front());
  endtask

  task automatic model_reset();
    q0.delete();
    q1.delete();
    for (int k = 0; k < 2; k++) begin
      ovf_m[k] = 1'b0;
      thr_m[k] = '0;
      irq_m[k] = 1'b0;
    end
  endtask

  function automatic logic [15:0] status_m(input int u);
    int n;
    n = qsize(u);
    return {ovf_m[u], n == DEPTH, n == 0, 13'(n)};
  endfunction

  function automatic logic [15:0] rd_exp(input int u, input logic [1:0] off);
    case (off)
      2'd1:    return status_m(u);
      2'd3:    return IRQ_EN ? {12'h000, thr_m[u]} : 16'h0000;
      default: return 16'h0000;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock edge: model pops for both instances, optional access effect on u
  task automatic clk_edge(input int u, input bit acc, input bit wr,
                          input logic [1:0] off, input logic [15:0] wd);
    bit pop_n [2];
    bit irq_n [2];
    bit full_pre;
    for (int k = 0; k < 2; k++) begin
      irq_n[k] = IRQ_EN && (((thr_m[k] != 0) && (qsize(k) >= int'(thr_m[k]))) || ovf_m[k]);
      pop_n[k] = mready[k] && (qsize(k) > 0);
    end
    full_pre = (qsize(u) == DEPTH);
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (pop_n[k]) qpop(k);
      irq_m[k] = irq_n[k];
    end
    if (acc && wr) begin
      case (off)
        2'd0: if (full_pre) ovf_m[u] = 1'b1; else qpush(u, wd);
        2'd2: begin
          if (wd[0]) begin
            if (u == 0) q0.delete(); else q1.delete();
          end
          if (wd[1]) ovf_m[u] = 1'b0;
        end
        2'd3: if (IRQ_EN) thr_m[u] = wd[3:0];
        default: ;
      endcase
    end
    #1;
    for (int k = 0; k < 2; k++) begin
      check($sformatf("m_valid%0d", k), mvalid[k], qsize(k) != 0);
      if (qsize(k) != 0) check($sformatf("m_data%0d", k), mdata[k], qhead(k));
      check($sformatf("irq%0d", k), irq[k], irq_m[k]);
    end
  endtask

  task automatic idle(input int u, input bit mr, input int n);
    mready[u] = mr;
    for (int i = 0; i < n; i++) clk_edge(u, 1'b0, 1'b0, 2'd0, 16'h0);
    mready[u] = 1'b0;
  endtask

  // Full bus transaction with cycle-exact ack/latency checks
  task automatic access(input int u, input bit wr, input bit rd, input logic [15:0] addr,
                        input logic [15:0] wd, input bit mr, input bit mr_ack_only,
                        input int abort_at, output logic [15:0] rdata);
    int          ws;
    int          rel;
    bit          hit;
    logic [1:0]  off;
    logic [15:0] exp;
    ws    = ws_of(u);
    rel   = int'(addr) - base_of(u);
    hit   = (wr ^ rd) && rel >= 0 && rel < 4;
    off   = 2'(rel);
    rdata = '0;
    sreq[u] = 1'b1; swrite[u] = wr; sread[u] = rd; saddr[u] = addr; swdata[u] = wd;
    mready[u] = mr && !mr_ack_only;
    check("sack_idle", sack[u], 1'b0);
    clk_edge(u, 1'b0, 1'b0, 2'd0, 16'h0);
    if (!hit) begin
      for (int k = 0; k < ws + 3; k++) begin
        check("sack_nohit", sack[u], 1'b0);
        check("srdata_nohit", srdata[u], 16'h0);
        clk_edge(u, 1'b0, 1'b0, 2'd0, 16'h0);
      end
      sreq[u] = 1'b0; swrite[u] = 1'b0; sread[u] = 1'b0; mready[u] = 1'b0;
      return;
    end
    for (int k = 1; k <= ws; k++) begin
      check("sack_wait", sack[u], 1'b0);
      check("srdata_wait", srdata[u], 16'h0);
      if (k == abort_at) begin
        sabort[u] = 1'b1;
        clk_edge(u, 1'b0, 1'b0, 2'd0, 16'h0);
        sabort[u] = 1'b0; sreq[u] = 1'b0; swrite[u] = 1'b0; sread[u] = 1'b0;
        mready[u] = 1'b0;
        for (int j = 0; j < 4; j++) begin
          check("sack_abort", sack[u], 1'b0);
          clk_edge(u, 1'b0, 1'b0, 2'd0, 16'h0);
        end
        return;
      end
      clk_edge(u, 1'b0, 1'b0, 2'd0, 16'h0);
    end
    if (mr_ack_only) mready[u] = mr;
    exp = rd ? rd_exp(u, off) : 16'h0;
    check("sack_ack", sack[u], 1'b1);
    check("srdata_ack", srdata[u], exp);
    rdata = srdata[u];
    clk_edge(u, 1'b1, wr, off, wd);
    sreq[u] = 1'b0; swrite[u] = 1'b0; sread[u] = 1'b0; mready[u] = 1'b0;
    check("sack_after", sack[u], 1'b0);
    check("srdata_after", srdata[u], 16'h0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] rdv;
    int          u, a, sel, ab;
    bit          wr, rd;
    logic [15:0] wd;

    for (int k = 0; k < 2; k++) begin
      sreq[k] = 0; swrite[k] = 0; sread[k] = 0; sabort[k] = 0; mready[k] = 0;
      saddr[k] = '0; swdata[k] = '0;
    end
    model_reset();

    // Reset state
    #2 rst = 1'b1;
    #10;
    for (int k = 0; k < 2; k++) begin
      check("rst_sack", sack[k], 1'b0);
      check("rst_srdata", srdata[k], 16'h0);
      check("rst_mvalid", mvalid[k], 1'b0);
      check("rst_mdata", mdata[k], 16'h0);
      check("rst_irq", irq[k], 1'b0);
    end
    #10 rst = 1'b0;

    // Directed vector table
    tbl.push_back('{0, 0, 1, 0, 16'h0000, 16'hCAFE, 0, 0, 0, 16'h0000});
    tbl.push_back('{0, 0, 1, 0, 16'h0000, 16'hDEAD, 0, 0, 0, 16'h0000});
    tbl.push_back('{0, 0, 0, 1, 16'h0001, 16'h0000, 0, 0, 1, 16'h0002});
    tbl.push_back('{0, 1, 0, 0, 16'h0000, 16'h0000, 1, 3, 0, 16'h0000});
    tbl.push_back('{0, 0, 0, 1, 16'h0001, 16'h0000, 0, 0, 1, 16'h2000});
    tbl.push_back('{0, 0, 0, 1, 16'h0000, 16'h0000, 0, 0, 1, 16'h0000});
    tbl.push_back('{0, 0, 1, 0, 16'h0002, 16'h0000, 0, 0, 0, 16'h0000});
    tbl.push_back('{0, 0, 0, 1, 16'h0002, 16'h0000, 0, 0, 1, 16'h0000});
    tbl.push_back('{0, 0, 1, 0, 16'h0003, 16'h0005, 0, 0, 0, 16'h0000});
    tbl.push_back('{0, 0, 0, 1, 16'h0003, 16'h0000, 0, 0, 1, IRQ_EN ? 16'h0005 : 16'h0000});
    tbl.push_back('{0, 0, 1, 0, 16'h0003, 16'h0000, 0, 0, 0, 16'h0000});
    tbl.push_back('{0, 0, 1, 0, 16'h0004, 16'h1111, 0, 0, 0, 16'h0000});
    tbl.push_back('{0, 0, 0, 1, 16'h0001, 16'h0000, 0, 0, 1, 16'h2000});
    tbl.push_back('{0, 0, 1, 1, 16'h0000, 16'h2222, 0, 0, 0, 16'h0000});
    tbl.push_back('{0, 0, 0, 1, 16'h0001, 16'h0000, 0, 0, 1, 16'h2000});
    tbl.push_back('{1, 0, 1, 0, 16'h003F, 16'h3333, 0, 0, 0, 16'h0000});
    tbl.push_back('{1, 0, 1, 0, 16'h0044, 16'h4444, 0, 0, 0, 16'h0000});
    tbl.push_back('{1, 0, 0, 1, 16'h0041, 16'h0000, 0, 0, 1, 16'h2000});
    foreach (tbl[i]) begin
      if (tbl[i].kind == 1) idle(tbl[i].u, tbl[i].mr, tbl[i].ncyc);
      else begin
        access(tbl[i].u, tbl[i].wr, tbl[i].rd, tbl[i].addr, tbl[i].wd, tbl[i].mr, 1'b0, 0, rdv);
        if (tbl[i].do_chk) check($sformatf("vec%0d_rdata", i), rdv, tbl[i].exp);
      end
    end

    // Overflow: nine pushes into an eight-deep FIFO, then clear ovf
    for (int i = 0; i < 9; i++) access(0, 1, 0, 16'h0000, 16'h1000 + 16'(i), 0, 0, 0, rdv);
    access(0, 0, 1, 16'h0001, 16'h0, 0, 0, 0, rdv);
    check("status_overflow", rdv, 16'hC008);
    access(0, 1, 0, 16'h0002, 16'h0002, 0, 0, 0, rdv);
    access(0, 0, 1, 16'h0001, 16'h0, 0, 0, 0, rdv);
    check("status_ovf_clr", rdv, 16'h4008);

    // Push to full FIFO with a pop in the ack cycle: dropped, ovf set, count 7
    access(0, 1, 0, 16'h0000, 16'h1234, 1, 1, 0, rdv);
    access(0, 0, 1, 16'h0001, 16'h0, 0, 0, 0, rdv);
    check("status_full_pop", rdv, 16'h8007);
    access(0, 1, 0, 16'h0002, 16'h0003, 0, 0, 0, rdv);
    access(0, 0, 1, 16'h0001, 16'h0, 0, 0, 0, rdv);
    check("status_flush", rdv, 16'h2000);

    // Wait-state latency and abort in the second wait cycle
    access(1, 0, 1, 16'h0041, 16'h0, 0, 0, 0, rdv);
    check("ws3_status", rdv, 16'h2000);
    access(1, 1, 0, 16'h0040, 16'h00A1, 0, 0, 0, rdv);
    access(1, 1, 0, 16'h0040, 16'h00A2, 0, 0, 0, rdv);
    access(1, 1, 0, 16'h0040, 16'h00A3, 0, 0, 2, rdv);
    access(1, 0, 1, 16'h0041, 16'h0, 0, 0, 0, rdv);
    check("abort_status", rdv, 16'h0002);

    // Interrupt threshold then flush
    access(0, 1, 0, 16'h0003, 16'h0004, 0, 0, 0, rdv);
    for (int i = 0; i < 4; i++) access(0, 1, 0, 16'h0000, 16'h2000 + 16'(i), 0, 0, 0, rdv);
    idle(0, 0, 1);
    check("irq_threshold", irq[0], IRQ_EN);
    access(0, 1, 0, 16'h0002, 16'h0001, 0, 0, 0, rdv);
    idle(0, 0, 1);
    check("irq_after_flush", irq[0], 1'b0);
    access(0, 1, 0, 16'h0003, 16'h0000, 0, 0, 0, rdv);

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      u   = int'($urandom_range(0, 1));
      sel = int'($urandom_range(0, 9));
      case (sel)
        0, 1, 2, 3: a = 0;
        4:          a = 1;
        5:          a = 2;
        6:          a = 3;
        7:          a = -1;
        8:          a = 4;
        default:    a = 1;
      endcase
      sel = int'($urandom_range(0, 9));
      case (sel)
        0:             begin wr = 1; rd = 1; end
        1:             begin wr = 0; rd = 0; end
        2, 3, 4, 5, 6: begin wr = 1; rd = 0; end
        default:       begin wr = 0; rd = 1; end
      endcase
      wd = 16'($urandom);
      if (a == 2 && $urandom_range(0, 3) != 0) wd[0] = 1'b0;
      ab = (u == 1 && $urandom_range(0, 7) == 0) ? int'($urandom_range(1, 3)) : 0;
      access(u, wr, rd, 16'(base_of(u) + a), wd, 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), ab, rdv);
      if ($urandom_range(0, 3) == 0) idle(u, 1'($urandom_range(0, 1)), int'($urandom_range(1, 3)));
    end

    // Reset in the middle of a wait-stated access
    access(1, 1, 0, 16'h0040, 16'h00B1, 0, 0, 0, rdv);
    sreq[1] = 1'b1; swrite[1] = 1'b1; saddr[1] = 16'h0040; swdata[1] = 16'hBEEF;
    clk_edge(1, 1'b0, 1'b0, 2'd0, 16'h0);
    clk_edge(1, 1'b0, 1'b0, 2'd0, 16'h0);
    rst = 1'b1;
    #1;
    model_reset();
    for (int k = 0; k < 2; k++) begin
      check("midrst_sack", sack[k], 1'b0);
      check("midrst_mvalid", mvalid[k], 1'b0);
      check("midrst_mdata", mdata[k], 16'h0);
      check("midrst_irq", irq[k], 1'b0);
    end
    sreq[1] = 1'b0; swrite[1] = 1'b0;
    #1 rst = 1'b0;
    for (int j = 0; j < 5; j++) begin
      clk_edge(1, 1'b0, 1'b0, 2'd0, 16'h0);
      check("midrst_noack", sack[1], 1'b0);
    end
    access(1, 0, 1, 16'h0041, 16'h0, 0, 0, 0, rdv);
    check("midrst_status1", rdv, 16'h2000);
    access(0, 0, 1, 16'h0001, 16'h0, 0, 0, 0, rdv);
    check("midrst_status0", rdv, 16'h2000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
